// File: rtl/ysyx_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment rule used to reject an access before it reaches the bus.
package ysyx_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RSP,
    LSU_DONE
  } lsu_state_e;

  // Size codes outside B/H/W have no legal alignment and are faulted.
  function automatic logic lsu_misaligned(input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
    case (func3[1:0])
      2'b00:   lsu_misaligned = 1'b0;
      2'b01:   lsu_misaligned = addr_lo[0];
      2'b10:   lsu_misaligned = (addr_lo != 2'b00);
      default: lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering between the LSB-aligned core side and the word-aligned
// bus side: write strobe/data shift and load data shift plus extension.
module ysyx_lsu_align
  import ysyx_pkg::*;
#(
  parameter int BIT_W = 32
) (
  input  logic [2:0]       func3,
  input  logic [1:0]       addr_lo,
  input  logic             is_load,
  input  logic [BIT_W-1:0] wdata,
  input  logic [BIT_W-1:0] rdata_raw,
  output logic [3:0]       wstrb,
  output logic [BIT_W-1:0] wdata_lane,
  output logic [BIT_W-1:0] rdata_ext
);

  logic [4:0]       lane_sh;
  logic [BIT_W-1:0] rdata_sh;

  function automatic logic [BIT_W-1:0] extend(input logic [2:0]       f3,
                                              input logic [BIT_W-1:0] w);
    case (f3)
      F3_B:    extend = {{(BIT_W-8){w[7]}}, w[7:0]};
      F3_H:    extend = {{(BIT_W-16){w[15]}}, w[15:0]};
      F3_BU:   extend = {{(BIT_W-8){1'b0}}, w[7:0]};
      F3_HU:   extend = {{(BIT_W-16){1'b0}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign lane_sh    = {addr_lo, 3'b000};
  assign wdata_lane = wdata << lane_sh;
  assign rdata_sh   = rdata_raw >> lane_sh;
  assign rdata_ext  = extend(func3, rdata_sh);

  always_comb begin
    wstrb = 4'b0000;
    if (!is_load) begin
      case (func3[1:0])
        2'b00:   wstrb = 4'b0001 << addr_lo;
        2'b01:   wstrb = 4'b0011 << addr_lo;
        default: wstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: captures one EXU request, runs a single bus transaction
// (or faults it locally) and returns a one-cycle completion pulse.
module ysyx_lsu
  import ysyx_pkg::*;
#(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic [2:0]       lsu_func3,
  input  logic [BIT_W-1:0] lsu_wdata,
  output logic [BIT_W-1:0] lsu_rdata,
  output logic             lsu_exu_rvalid,
  output logic             lsu_exu_wready,
  output logic             lsu_err,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic             bus_we,
  output logic [BIT_W-1:0] bus_addr,
  output logic [BIT_W-1:0] bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic             bus_rsp_valid,
  input  logic [BIT_W-1:0] bus_rdata,
  input  logic             bus_err
);

  lsu_state_e       state_q, state_d;
  logic             capture, fault;
  logic             load_p0, err_p0;
  logic [BIT_W-1:0] addr_p0, wdata_p0, rdata_q;
  logic [2:0]       func3_p0;
  logic [3:0]       wstrb_lane;
  logic [BIT_W-1:0] wdata_lane, rdata_ext;
  logic             in_req, in_done;

  ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
    .func3      (func3_p0),
    .addr_lo    (addr_p0[1:0]),
    .is_load    (load_p0),
    .wdata      (wdata_p0),
    .rdata_raw  (bus_rdata),
    .wstrb      (wstrb_lane),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fault   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_avalid && (lsu_ren || lsu_wen)) begin
          capture = 1'b1;
          fault   = (lsu_ren && lsu_wen) || lsu_misaligned(lsu_func3, lsu_addr[1:0]);
          state_d = fault ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ:  if (bus_req_ready) state_d = LSU_RSP;
      LSU_RSP:  if (bus_rsp_valid) state_d = LSU_DONE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Control state: FSM, transaction kind, fault flag and the returned load word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      load_p0 <= 1'b0;
      err_p0  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        load_p0 <= lsu_ren;
        err_p0  <= fault;
        if (fault && lsu_ren) rdata_q <= '0;
      end else if (state_q == LSU_RSP && bus_rsp_valid) begin
        err_p0 <= bus_err;
        if (load_p0) rdata_q <= bus_err ? '0 : rdata_ext;
      end
    end
  end

  // Captured request operands; only observed while the FSM is past IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0  <= lsu_addr;
      func3_p0 <= lsu_func3;
      wdata_p0 <= lsu_wdata;
    end
  end

  assign in_req  = (state_q == LSU_REQ);
  assign in_done = (state_q == LSU_DONE);

  assign bus_req_valid  = in_req;
  assign bus_we         = in_req && !load_p0;
  assign bus_addr       = in_req ? {addr_p0[BIT_W-1:2], 2'b00} : '0;
  assign bus_wdata      = in_req ? wdata_lane : '0;
  assign bus_wstrb      = in_req ? wstrb_lane : 4'b0000;

  assign lsu_exu_rvalid = in_done && load_p0;
  assign lsu_exu_wready = in_done && !load_p0;
  assign lsu_err        = in_done && err_p0;
  assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: vector table of single transactions plus
// hand-written reset-abort sequences.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_avalid, lsu_ren, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_func3;
  logic        lsu_exu_rvalid, lsu_exu_wready, lsu_err;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_lsu #(.BIT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_avalid     (lsu_avalid),
    .lsu_ren        (lsu_ren),
    .lsu_wen        (lsu_wen),
    .lsu_addr       (lsu_addr),
    .lsu_func3      (lsu_func3),
    .lsu_wdata      (lsu_wdata),
    .lsu_rdata      (lsu_rdata),
    .lsu_exu_rvalid (lsu_exu_rvalid),
    .lsu_exu_wready (lsu_exu_wready),
    .lsu_err        (lsu_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rdata      (bus_rdata),
    .bus_err        (bus_err)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        berr;
    int          rwait;
    logic        exp_req;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_avalid    = 1'b0;
    lsu_ren       = 1'b0;
    lsu_wen       = 1'b0;
    lsu_addr      = '0;
    lsu_func3     = '0;
    lsu_wdata     = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata     = '0;
    bus_err       = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reqv"},   {31'd0, bus_req_valid}, 32'd0);
    chk({tag, "_addr"},   bus_addr, 32'd0);
    chk({tag, "_wstrb"},  {28'd0, bus_wstrb}, 32'd0);
    chk({tag, "_wdata"},  bus_wdata, 32'd0);
    chk({tag, "_pulse"},  {30'd0, lsu_exu_rvalid, lsu_exu_wready}, 32'd0);
    chk({tag, "_err"},    {31'd0, lsu_err}, 32'd0);
    chk({tag, "_rdata"},  lsu_rdata, 32'd0);
  endtask

  // Entered and left on a falling edge; drives one request to completion.
  task automatic run_txn(input vec_t v, input int id);
    bit pending = 0, saw_req = 0, got = 0;
    int waits = v.rwait;
    int lat = 0;
    lsu_avalid = 1'b1;
    lsu_ren    = v.ren;
    lsu_wen    = v.wen;
    lsu_addr   = v.addr;
    lsu_func3  = v.f3;
    lsu_wdata  = v.wdata;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        lsu_addr  = 32'hFFFF_FFFF;
        lsu_wdata = 32'h5A5A_5A5A;
      end
      bus_rsp_valid = pending;
      bus_rdata     = v.rdata;
      bus_err       = v.berr;
      pending       = 0;
      if (bus_req_valid) begin
        saw_req = 1;
        chk($sformatf("v%0d_baddr", id), bus_addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_bwe", id), {31'd0, bus_we}, {31'd0, v.wen});
        chk($sformatf("v%0d_wstrb", id), {28'd0, bus_wstrb}, {28'd0, v.exp_strb});
        chk($sformatf("v%0d_bwdata", id), bus_wdata, v.exp_wdata);
        if (waits > 0) begin
          bus_req_ready = 1'b0;
          waits--;
        end else begin
          bus_req_ready = 1'b1;
          pending = 1;
        end
      end else begin
        bus_req_ready = 1'b0;
      end
      if (lsu_exu_rvalid || lsu_exu_wready) begin
        got = 1;
        chk($sformatf("v%0d_kind", id), {30'd0, lsu_exu_rvalid, lsu_exu_wready},
            v.exp_rv ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_err", id), {31'd0, lsu_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_rdata", id), lsu_rdata, v.exp_rdata);
        chk($sformatf("v%0d_lat", id), lat, v.exp_lat);
        chk($sformatf("v%0d_busused", id), {31'd0, saw_req}, {31'd0, v.exp_req});
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL v%0d_timeout actual=no_pulse required=pulse", id);
    end
    idle_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_onepulse", id), {30'd0, lsu_exu_rvalid, lsu_exu_wready}, 32'd0);
    chk($sformatf("v%0d_heldrdata", id), lsu_rdata, v.exp_rdata);
  endtask

  initial begin
    int pulses;
    vec_t fin;
    //          ren  wen  addr          f3      wdata         rdata         berr wt req  rv   err  exp_rdata     strb     exp_wdata     lat
    vecs[0]  = '{1'b1,1'b0,32'h8000_0003,3'b000,32'h0000_0000,32'h80FF_FFFF,1'b0,0,1'b1,1'b1,1'b0,32'hFFFF_FF80,4'b0000,32'h0000_0000,3};
    vecs[1]  = '{1'b0,1'b1,32'h8000_0002,3'b001,32'h0000_1234,32'h0000_0000,1'b0,0,1'b1,1'b0,1'b0,32'hFFFF_FF80,4'b1100,32'h1234_0000,3};
    vecs[2]  = '{1'b1,1'b0,32'h8000_0001,3'b010,32'h0000_0000,32'hFFFF_FFFF,1'b0,0,1'b0,1'b1,1'b1,32'h0000_0000,4'b0000,32'h0000_0000,1};
    vecs[3]  = '{1'b1,1'b0,32'h8000_0002,3'b101,32'h0000_0000,32'hBEEF_0000,1'b1,0,1'b1,1'b1,1'b1,32'h0000_0000,4'b0000,32'h0000_0000,3};
    vecs[4]  = '{1'b1,1'b0,32'h1000_0002,3'b001,32'h0000_0000,32'hBEEF_1234,1'b0,0,1'b1,1'b1,1'b0,32'hFFFF_BEEF,4'b0000,32'h0000_0000,3};
    vecs[5]  = '{1'b1,1'b0,32'h1000_0001,3'b100,32'h0000_0000,32'h1234_A5FF,1'b0,0,1'b1,1'b1,1'b0,32'h0000_00A5,4'b0000,32'h0000_0000,3};
    vecs[6]  = '{1'b1,1'b0,32'h2000_0004,3'b010,32'h0000_0000,32'hDEAD_BEEF,1'b0,0,1'b1,1'b1,1'b0,32'hDEAD_BEEF,4'b0000,32'h0000_0000,3};
    vecs[7]  = '{1'b0,1'b1,32'h3000_0001,3'b000,32'hFFFF_FF7E,32'h0000_0000,1'b0,0,1'b1,1'b0,1'b0,32'hDEAD_BEEF,4'b0010,32'hFFFF_7E00,3};
    vecs[8]  = '{1'b0,1'b1,32'h3000_0008,3'b010,32'hCAFE_F00D,32'h0000_0000,1'b0,5,1'b1,1'b0,1'b0,32'hDEAD_BEEF,4'b1111,32'hCAFE_F00D,8};
    vecs[9]  = '{1'b0,1'b1,32'h3000_0003,3'b001,32'h0000_ABCD,32'h0000_0000,1'b0,0,1'b0,1'b0,1'b1,32'hDEAD_BEEF,4'b0000,32'h0000_0000,1};
    vecs[10] = '{1'b1,1'b1,32'h4000_0000,3'b010,32'h0000_0000,32'h0000_0000,1'b0,0,1'b0,1'b1,1'b1,32'h0000_0000,4'b0000,32'h0000_0000,1};
    vecs[11] = '{1'b1,1'b0,32'h4000_0000,3'b000,32'h0000_0000,32'h0000_007F,1'b0,0,1'b1,1'b1,1'b0,32'h0000_007F,4'b0000,32'h0000_0000,3};
    vecs[12] = '{1'b0,1'b1,32'h5000_0000,3'b010,32'h0000_0001,32'h0000_0000,1'b1,0,1'b1,1'b0,1'b1,32'h0000_007F,4'b1111,32'h0000_0001,3};
    vecs[13] = '{1'b1,1'b0,32'h5000_0000,3'b001,32'h0000_0000,32'h0000_8001,1'b0,2,1'b1,1'b1,1'b0,32'hFFFF_8001,4'b0000,32'h0000_0000,5};

    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Reset while waiting for the response; the late response must be dropped.
    lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_addr = 32'h6000_0000; lsu_func3 = 3'b010;
    bus_req_ready = 1'b1;
    @(negedge clk);
    chk("rsp_cut_inreq", {31'd0, bus_req_valid}, 32'd1);
    @(negedge clk);
    chk("rsp_cut_inrsp", {31'd0, bus_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk_quiet("rsp_cut");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'h1234_5678;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      if (lsu_exu_rvalid || lsu_exu_wready || bus_req_valid) pulses++;
    end
    chk("rsp_cut_nopulse", pulses, 0);
    chk("rsp_cut_rdata", lsu_rdata, 32'd0);

    // Reset while the request is stalled drops bus_req_valid at once.
    lsu_avalid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h7000_0004; lsu_func3 = 3'b010;
    lsu_wdata = 32'h1111_2222;
    @(negedge clk);
    chk("req_cut_before", {31'd0, bus_req_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk_quiet("req_cut");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    fin = '{1'b1,1'b0,32'h8000_0003,3'b000,32'h0,32'h80FF_FFFF,1'b0,0,1'b1,1'b1,1'b0,32'hFFFF_FF80,4'b0000,32'h0,3};
    run_txn(fin, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
